// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks: default operand width,
// the multiplier state encoding and the bit-counter width helper.
package rsa_pkg;

    localparam int DEFAULT_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        SUB  = 2'd2
    } state_t;

    // Number of bits needed to index one operand bit; never less than one.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mont_cond_sub.sv
// Combinational Montgomery final correction: returns c - m when c >= m,
// otherwise c, truncated to WIDTH bits. c is the (WIDTH+2)-bit accumulator.
module mont_cond_sub
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH+1:0] c,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] corrected
);

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] diff;
    logic [WIDTH+1:0] sel;
    logic [1:0]       unused_hi;

    // Compare and subtract at full accumulator width so nothing is lost
    // before the choice is made; only the low WIDTH bits are meaningful.
    always_comb begin
        m_ext = {2'b00, m};
        diff  = c - m_ext;
        sel   = (c >= m_ext) ? diff : c;
    end

    assign corrected = sel[WIDTH-1:0];
    assign unused_hi = sel[WIDTH+1:WIDTH];

endmodule

// File: rtl/montgomery_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = a * b * 2^-WIDTH mod m.
// One bit of a per clock (LSB first), then one conditional subtraction.
// Latency from the start edge to the done edge is WIDTH+1 clocks.
module montgomery_mult_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] reg_m;
    logic [WIDTH+1:0] acc;
    logic [CW-1:0]    idx;

    logic             a_bit;
    logic [WIDTH+1:0] partial;
    logic [WIDTH+1:0] reduced;
    logic [WIDTH+1:0] acc_next;
    logic [WIDTH-1:0] corrected;

    logic load;
    logic step;
    logic finish;

    // One Montgomery iteration: add b if the current bit of a is set, add m
    // to make the sum even, then halve. With acc < 2m and b < m the sum
    // stays below 4m, so WIDTH+2 bits never overflow.
    always_comb begin
        a_bit    = reg_a[idx];
        partial  = acc + (a_bit ? {2'b00, reg_b} : '0);
        reduced  = partial[0] ? (partial + {2'b00, reg_m}) : partial;
        acc_next = reduced >> 1;
    end

    mont_cond_sub #(
        .WIDTH(WIDTH)
    ) u_cond_sub (
        .c        (acc),
        .m        (reg_m),
        .corrected(corrected)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and datapath strobes; start is only honoured in IDLE.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = LOOP;
                end
            end
            LOOP: begin
                step = 1'b1;
                if (idx == LAST) begin
                    next_state = SUB;
                end
            end
            SUB: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture on acceptance and accumulator/counter advance per bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_m <= '0;
            acc   <= '0;
            idx   <= '0;
        end else if (load) begin
            reg_a <= in_a;
            reg_b <= in_b;
            reg_m <= in_m;
            acc   <= '0;
            idx   <= '0;
        end else if (step) begin
            acc <= acc_next;
            idx <= idx + 1'b1;
        end
    end

    // Registered outputs: done pulses for the single SUB edge and result is
    // updated only then, holding its value until the next completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                result <= corrected;
            end
        end
    end

endmodule

// File: tb/tb_montgomery_mult_serial.sv
// Bench for montgomery_mult_serial: an 8-bit and a 512-bit instance, each with
// an expected-result queue filled at issue time and drained by a monitor.
module tb_montgomery_mult_serial;

    localparam int WS = 8;
    localparam int WL = 512;

    typedef struct {
        logic [511:0] exp;
        int           due;
    } item_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start_s = 1'b0;
    logic          start_l = 1'b0;
    logic [WS-1:0] a_s = '0, b_s = '0, m_s = '0;
    logic [WL-1:0] a_l = '0, b_l = '0, m_l = '0;
    logic [WS-1:0] res_s;
    logic [WL-1:0] res_l;
    logic          done_s, done_l;

    int    cyc = 0;
    int    checks_total = 0;
    int    checks_passed = 0;
    item_t q_s[$];
    item_t q_l[$];
    item_t mon_s_it, mon_l_it;

    montgomery_mult_serial #(.WIDTH(WS)) dut_s (
        .clk(clk), .resetn(resetn), .start(start_s),
        .in_a(a_s), .in_b(b_s), .in_m(m_s),
        .result(res_s), .done(done_s)
    );

    montgomery_mult_serial #(.WIDTH(WL)) dut_l (
        .clk(clk), .resetn(resetn), .start(start_l),
        .in_a(a_l), .in_b(b_l), .in_m(m_l),
        .result(res_l), .done(done_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks_total++;
        if (act === req) checks_passed++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    endfunction

    // Reference: reduce a*b mod m, then divide by 2 modulo m w times.
    function automatic logic [511:0] mont_ref(input logic [511:0] a, input logic [511:0] b,
                                              input logic [511:0] m, input int w);
        logic [1023:0] x;
        logic [1023:0] mm;
        mm = {512'b0, m};
        x  = ({512'b0, a} * {512'b0, b}) % mm;
        for (int k = 0; k < w; k++) x = x[0] ? ((x + mm) >> 1) : (x >> 1);
        return x[511:0];
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (resetn) begin
            if (done_s) begin
                if (q_s.size() == 0) begin
                    check("small_spurious_done", {511'b0, done_s}, 512'b0);
                end else begin
                    mon_s_it = q_s.pop_front();
                    check("small_result", {504'b0, res_s}, mon_s_it.exp);
                    check("small_latency", 512'(cyc), 512'(mon_s_it.due));
                end
            end else if (q_s.size() != 0 && cyc > q_s[0].due) begin
                check("small_done_timeout", {511'b0, done_s}, 512'd1);
                mon_s_it = q_s.pop_front();
            end
        end
    end

    // Monitor for the 512-bit instance.
    always @(negedge clk) begin
        if (resetn) begin
            if (done_l) begin
                if (q_l.size() == 0) begin
                    check("large_spurious_done", {511'b0, done_l}, 512'b0);
                end else begin
                    mon_l_it = q_l.pop_front();
                    check("large_result", res_l, mon_l_it.exp);
                    check("large_latency", 512'(cyc), 512'(mon_l_it.due));
                end
            end else if (q_l.size() != 0 && cyc > q_l[0].due) begin
                check("large_done_timeout", {511'b0, done_l}, 512'd1);
                mon_l_it = q_l.pop_front();
            end
        end
    end

    // Called at a falling edge; the next rising edge accepts the operation.
    task automatic issue_s(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        item_t it;
        a_s = a; b_s = b; m_s = m; start_s = 1'b1;
        it.exp = mont_ref({504'b0, a}, {504'b0, b}, {504'b0, m}, WS);
        it.due = cyc + WS + 2;
        q_s.push_back(it);
        @(negedge clk);
        start_s = 1'b0;
        a_s = 8'($urandom); b_s = 8'($urandom); m_s = 8'($urandom);
    endtask

    task automatic issue_l(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m);
        item_t it;
        a_l = a; b_l = b; m_l = m; start_l = 1'b1;
        it.exp = mont_ref(a, b, m, WL);
        it.due = cyc + WL + 2;
        q_l.push_back(it);
        @(negedge clk);
        start_l = 1'b0;
        a_l = rand512(); b_l = rand512(); m_l = rand512();
    endtask

    task automatic drain_s();
        int k = 0;
        while (q_s.size() != 0 && k < 4 * WS + 20) begin
            @(negedge clk); #1; k++;
        end
        if (q_s.size() != 0) begin
            check("small_drain", 512'(q_s.size()), 512'd0);
            q_s.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic drain_l();
        int k = 0;
        while (q_l.size() != 0 && k < 3 * WL) begin
            @(negedge clk); #1; k++;
        end
        if (q_l.size() != 0) begin
            check("large_drain", 512'(q_l.size()), 512'd0);
            q_l.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [511:0] ra, rb, rm;
        logic [7:0]   sa, sb, sm;
        int           d;
        int           n0;

        #12;
        check("reset_small_done", {511'b0, done_s}, 512'b0);
        check("reset_small_result", {504'b0, res_s}, 512'b0);
        check("reset_large_done", {511'b0, done_l}, 512'b0);
        check("reset_large_result", res_l, 512'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed 8-bit cases with m = 13.
        issue_s(8'd1, 8'd9, 8'd13);  drain_s();
        issue_s(8'd12, 8'd12, 8'd13); drain_s();
        issue_s(8'd9, 8'd9, 8'd13);  drain_s();
        issue_s(8'd0, 8'd7, 8'd13);  drain_s();

        // Back-to-back: second start presented during the done cycle.
        issue_s(8'd5, 8'd7, 8'd13);
        d = q_s[0].due;
        while (cyc < d) @(negedge clk);
        issue_s(8'd11, 8'd3, 8'd13);
        drain_s();

        // Random 8-bit operations.
        for (int n = 0; n < 20; n++) begin
            sm = 8'($urandom_range(3, 255)) | 8'd1;
            sa = 8'($urandom % sm);
            sb = 8'($urandom % sm);
            issue_s(sa, sb, sm);
            drain_s();
        end

        // Largest modulus, largest operands.
        rm = '1;
        issue_l(rm - 1, rm - 1, rm);
        drain_l();

        // Random 512-bit operations.
        for (int n = 0; n < 40; n++) begin
            rm = rand512() | 512'd1;
            ra = rand512() % rm;
            rb = rand512() % rm;
            issue_l(ra, rb, rm);
            drain_l();
        end

        // A start pulse during LOOP must be ignored.
        rm = rand512() | 512'd1;
        issue_l(rand512() % rm, rand512() % rm, rm);
        repeat (100) @(negedge clk);
        a_l = rand512(); b_l = rand512(); m_l = rand512() | 512'd1;
        start_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        drain_l();
        repeat (WL + 10) @(negedge clk);

        // Asynchronous reset 200 cycles into an operation.
        rm = rand512() | 512'd1;
        n0 = cyc;
        issue_l(rand512() % rm, rand512() % rm, rm);
        while (cyc < n0 + 200) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midop_reset_done", {511'b0, done_l}, 512'b0);
        check("midop_reset_result", res_l, 512'b0);
        q_l.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        rm = rand512() | 512'd1;
        issue_l(rand512() % rm, rand512() % rm, rm);
        drain_l();

        // Back-to-back on the wide instance.
        rm = rand512() | 512'd1;
        issue_l(rand512() % rm, rand512() % rm, rm);
        d = q_l[0].due;
        while (cyc < d) @(negedge clk);
        issue_l(rand512() % rm, rand512() % rm, rm);
        drain_l();
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
